// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, state encoding and helpers for the adder arbiter
package adder_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_N_OPS  = 4;
  localparam int DEF_SUM_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operand index width; a single-operand job still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_accum_dp.sv
// rtl/adder_accum_dp.sv - latched operand register, operand select and accumulator
module adder_accum_dp
  import adder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_OPS  = DEF_N_OPS,
  parameter int SUM_W  = DEF_SUM_W,
  parameter int IDX_W  = idx_width(DEF_N_OPS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic                      add_i,
  input  logic [N_OPS*DATA_W-1:0]   opnd_i,
  input  logic [IDX_W-1:0]          idx_i,
  output logic [SUM_W-1:0]          sum_o
);

  logic [N_OPS*DATA_W-1:0] op_q;
  logic [SUM_W-1:0]        acc_q;
  logic [DATA_W-1:0]       sel;

  // sum_o is the accumulator plus the currently indexed operand, zero-extended.
  always_comb begin
    sel   = op_q[idx_i*DATA_W +: DATA_W];
    sum_o = acc_q + SUM_W'(sel);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q  <= '0;
      acc_q <= '0;
    end else if (load_i) begin
      op_q  <= opnd_i;
      acc_q <= '0;
    end else if (add_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - two-requester round-robin front end for the shared accumulate datapath
module adder_arbiter
  import adder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_OPS  = DEF_N_OPS,
  parameter int SUM_W  = DEF_SUM_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic [N_OPS*DATA_W-1:0] opnd0,
  input  logic                    req1,
  input  logic [N_OPS*DATA_W-1:0] opnd1,
  output logic [1:0]              gnt,
  output logic [1:0]              done,
  output logic                    busy,
  output logic [SUM_W-1:0]        o_sum
);

  localparam int IDX_W = idx_width(N_OPS);

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic              busy_q, busy_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SUM_W-1:0]  sum_q, sum_d;

  logic              any_req;
  logic              winner;
  logic              dp_load;
  logic              dp_add;
  logic [SUM_W-1:0]  dp_sum;

  // On a tie the requester that did not finish last wins.
  assign any_req = req0 | req1;
  assign winner  = (req0 & req1) ? ~last_q : req1;
  assign dp_load = (state_q == IDLE) && any_req;
  assign dp_add  = (state_q == ACC);

  adder_accum_dp #(
    .DATA_W (DATA_W),
    .N_OPS  (N_OPS),
    .SUM_W  (SUM_W),
    .IDX_W  (IDX_W)
  ) u_dp (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (dp_load),
    .add_i  (dp_add),
    .opnd_i (winner ? opnd1 : opnd0),
    .idx_i  (idx_q),
    .sum_o  (dp_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    done_d  = '0;
    busy_d  = busy_q;
    owner_d = owner_q;
    last_d  = last_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = {winner, ~winner};
          owner_d = winner;
          busy_d  = 1'b1;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_OPS - 1)) begin
          sum_d   = dp_sum;
          done_d  = {owner_q, ~owner_q};
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = owner_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt   = gnt_q;
    done  = done_q;
    busy  = busy_q;
    o_sum = sum_q;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of a single shared accumulate datapath.
- A granted request has its four 4-bit operands latched, then summed one operand per cycle into a 16-bit accumulator.
- The result is returned with a one-cycle done pulse to the owning requester.
- Sits between client logic and the adder datapath, so that one adder serves multiple multi-operand sum jobs.

Parameters:
- DATA_W, 4, width of each operand.
- N_OPS, 4, operands per job. Packed operand bus width is N_OPS*DATA_W.
- SUM_W, 16, width of the accumulator and of o_sum.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 job request, level.
- opnd0  in  N_OPS*DATA_W  requester 0 operands, packed {D,C,B,A}, A in LSBs.
- req1  in  1  requester 1 job request, level.
- opnd1  in  N_OPS*DATA_W  requester 1 operands, packed as opnd0.
- gnt  out  2  one-cycle grant pulse; bit i means requester i's operands were latched.
- done  out  2  one-cycle completion pulse; bit i means o_sum belongs to requester i.
- busy  out  1  high from grant through done inclusive.
- o_sum  out  SUM_W  result of the last completed job; holds until the next done.

Behaviour:
- Reset (synchronous, dominates everything):
  - state=IDLE, gnt=0, done=0, busy=0, o_sum=0, acc=0, idx=0.
  - last_grant=1, so requester 0 wins the first tie.
- States: IDLE -> ACC -> DONE -> IDLE.
- IDLE, at a rising edge with any req high:
  - Single req: that requester wins.
  - Both high: the requester not equal to last_grant wins.
  - Winner's opnd is latched into op_reg.
  - acc<=0, idx<=0, gnt[winner]<=1 for one cycle, owner<=winner, busy<=1, state<=ACC.
  - No req: remain in IDLE, all pulses 0.
- ACC, each edge:
  - acc<=acc+zero-extend(op_reg[idx]); idx<=idx+1.
  - At idx==N_OPS-1: o_sum<=acc+zero-extend(op_reg[idx]), done[owner]<=1, state<=DONE.
- DONE, one cycle:
  - done visible, busy still 1.
  - Next edge: last_grant<=owner, busy<=0, done<=0, state<=IDLE.
- Latency, with E0 the sampling edge:
  - gnt high after E0.
  - done and o_sum valid after E0+N_OPS edges (E4 with defaults).
  - Back in IDLE after E5; the earliest next grant is at E6.
- Width rule:
  - Operands are zero-extended to SUM_W.
  - Max sum N_OPS*(2^DATA_W-1) (=60) fits, so no overflow handling is needed.
  - Wrap modulo 2^SUM_W is acceptable if parameters are changed.
- Request semantics:
  - req is sampled only in IDLE.
  - Changes to req or opnd during ACC/DONE are ignored; the job completes on the latched operands.
  - A req held high after its done is treated as a new job, subject to round-robin.
- Simultaneous req0 and req1 continuously: grants alternate 0,1,0,1...
- gnt and done are never asserted in the same cycle.
- At most one bit of gnt, and one bit of done, is set at a time.
- Reset mid-ACC: job aborted, no done pulse, o_sum=0 next cycle.

Decomposition:
- Package adder_pkg holds:
  - state encoding constants IDLE/ACC/DONE.
  - defaults DATA_W, N_OPS, SUM_W.
  - the index width, clog2(N_OPS).
- Sub-module adder_accum_dp holds the datapath:
  - op_reg and operand select mux by idx.
  - SUM_W adder and acc register, with clear/load/add controls.
- The FSM, round-robin pointer and owner tracking stay in adder_arbiter.

Test Plan:
- Basic job: after reset, req0=1, opnd0=16'h8420 (A=0,B=2,C=4,D=8).
  - Expect gnt=2'b01 one cycle after the sampling edge.
  - Expect done=2'b01 and o_sum=14 four edges later; busy high across those 5 cycles.
- Max operands: req1 only, opnd1=16'hFFFF.
  - Expect gnt=2'b10, done=2'b10, o_sum=60.
- Tie and fairness: req0 and req1 held high, opnd0=16'h1111, opnd1=16'h2222.
  - Expect grant order 0,1,0,1.
  - Expect o_sum alternating 4, 8; each done matches its prior gnt bit.
- Operand change mid-job: req0 with 16'h8420; during ACC change opnd0 to 16'hFFFF and drop req0.
  - Expect o_sum=14, done=2'b01, and no further grant.
- Reset mid-operation: assert rst for one cycle, two edges after gnt.
  - Expect no done pulse; o_sum=0, busy=0, state IDLE.
  - A subsequent tie grants requester 0 first.
- Idle hold: no requests for 20 cycles after a job with o_sum=14.
  - Expect o_sum stays 14; gnt, done and busy stay 0.
